// File: rtl/powerlink_pdo_filter.sv
// powerlink_pdo_filter
//   Watches a received Ethernet byte stream (preamble/SFD stripped) and picks
//   out POWERLINK PReq (MASTER=0) or PRes (MASTER=1) frames addressed to / sent
//   by the local node. The payload is collected in a shadow buffer and only
//   copied to the outputs once the frame has ended with every required byte
//   present.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   node      local node ID, sampled when a frame starts
//   rx_data   received byte; byte 0 = first destination MAC byte
//   rx_rdy    one-cycle strobe qualifying rx_data
//   rx_busy   high for the whole frame; low = end of frame
//   pdo_st    one-cycle pulse, accepted frame committed to the outputs
//   pdo_err   one-cycle pulse, header matched but frame truncated
//   pdo_src   source node of last committed frame
//   pdo_size  Size field of last committed frame
//   pdo_data  payload of last committed frame, byte k at [8k+7:8k]
//   drop_cnt  saturating count of skipped or truncated frames
module powerlink_pdo_filter #(
    parameter int unsigned MASTER        = 0,
    parameter int unsigned CHECK_NODE    = 1,
    parameter int unsigned PAYLOAD_BYTES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 node,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_rdy,
    input  logic                       rx_busy,
    output logic                       pdo_st,
    output logic                       pdo_err,
    output logic [7:0]                 pdo_src,
    output logic [15:0]                pdo_size,
    output logic [8*PAYLOAD_BYTES-1:0] pdo_data,
    output logic [15:0]                drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_SKIP
    } state_t;

    localparam logic [7:0]  MSG_TYPE = (MASTER != 0) ? 8'h04 : 8'h03;
    localparam logic        CHK_DST  = (CHECK_NODE != 0) && (MASTER == 0);
    localparam logic        CHK_SRC  = (CHECK_NODE != 0) && (MASTER != 0);
    localparam logic [15:0] PB16     = 16'(PAYLOAD_BYTES);

    state_t                     state_q, state_d;
    logic [10:0]                idx_q, idx_d;
    logic                       armed_q, armed_d;
    logic [7:0]                 node_q, node_d;
    logic [7:0]                 sh_src_q, sh_src_d;
    logic [15:0]                sh_size_q, sh_size_d;
    logic [8*PAYLOAD_BYTES-1:0] sh_data_q, sh_data_d;
    logic                       pdo_st_q, pdo_st_d;
    logic                       pdo_err_q, pdo_err_d;
    logic [7:0]                 pdo_src_q, pdo_src_d;
    logic [15:0]                pdo_size_q, pdo_size_d;
    logic [8*PAYLOAD_BYTES-1:0] pdo_data_q, pdo_data_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;

    logic [10:0] idx_inc;
    logic [15:0] need;
    logic [15:0] rcvd;
    logic        payload_done;
    logic [15:0] drop_inc;

    // idx_q holds the index of the next byte to arrive; it parks at 2047.
    assign idx_inc      = (idx_q == 11'h7FF) ? idx_q : idx_q + 11'd1;
    assign need         = (sh_size_q < PB16) ? sh_size_q : PB16;
    // Payload bytes seen so far; only meaningful once idx_q >= 24.
    assign rcvd         = {5'd0, idx_q} - 16'd24;
    assign payload_done = (rcvd >= need);
    assign drop_inc     = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        armed_d    = armed_q;
        node_d     = node_q;
        sh_src_d   = sh_src_q;
        sh_size_d  = sh_size_q;
        sh_data_d  = sh_data_q;
        pdo_st_d   = 1'b0;
        pdo_err_d  = 1'b0;
        pdo_src_d  = pdo_src_q;
        pdo_size_d = pdo_size_q;
        pdo_data_d = pdo_data_q;
        drop_cnt_d = drop_cnt_q;

        if (!rx_busy) begin
            // End of frame takes priority over a coincident rx_rdy.
            state_d = ST_IDLE;
            idx_d   = '0;
            armed_d = 1'b1;
            case (state_q)
                ST_PAYLOAD: begin
                    if (payload_done) begin
                        pdo_st_d   = 1'b1;
                        pdo_src_d  = sh_src_q;
                        pdo_size_d = sh_size_q;
                        pdo_data_d = sh_data_q;
                    end else begin
                        pdo_err_d  = 1'b1;
                        drop_cnt_d = drop_inc;
                    end
                end
                ST_HDR: begin
                    // Byte 14 already passed means a genuine frame got cut short.
                    if (idx_q >= 11'd15) begin
                        pdo_err_d  = 1'b1;
                        drop_cnt_d = drop_inc;
                    end
                end
                ST_SKIP: drop_cnt_d = drop_inc;
                default: ;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_d     = '0;
                    sh_src_d  = '0;
                    sh_size_d = '0;
                    sh_data_d = '0;
                    // armed_q stays low after reset until rx_busy has been seen
                    // low, so a frame already in flight is never picked up midway.
                    if (armed_q && rx_rdy) begin
                        state_d = ST_HDR;
                        idx_d   = 11'd1;
                        node_d  = node;
                    end
                end
                ST_HDR: begin
                    if (rx_rdy) begin
                        idx_d = idx_inc;
                        case (idx_q)
                            11'd12: if (rx_data != 8'h88) state_d = ST_SKIP;
                            11'd13: if (rx_data != 8'hAB) state_d = ST_SKIP;
                            11'd14: if (rx_data != MSG_TYPE) state_d = ST_SKIP;
                            11'd15: if (CHK_DST && (rx_data != node_q)) state_d = ST_SKIP;
                            11'd16: begin
                                sh_src_d = rx_data;
                                if (CHK_SRC && (rx_data != node_q)) state_d = ST_SKIP;
                            end
                            11'd22: sh_size_d[7:0] = rx_data;
                            11'd23: begin
                                sh_size_d[15:8] = rx_data;
                                state_d         = ST_PAYLOAD;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_rdy) begin
                        idx_d = idx_inc;
                        for (int unsigned k = 0; k < PAYLOAD_BYTES; k++) begin
                            if ((rcvd == 16'(k)) && (rcvd < need)) begin
                                sh_data_d[8*k +: 8] = rx_data;
                            end
                        end
                    end
                end
                ST_SKIP: begin
                    if (rx_rdy) idx_d = idx_inc;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            armed_q    <= 1'b0;
            node_q     <= '0;
            sh_src_q   <= '0;
            sh_size_q  <= '0;
            sh_data_q  <= '0;
            pdo_st_q   <= 1'b0;
            pdo_err_q  <= 1'b0;
            pdo_src_q  <= '0;
            pdo_size_q <= '0;
            pdo_data_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            armed_q    <= armed_d;
            node_q     <= node_d;
            sh_src_q   <= sh_src_d;
            sh_size_q  <= sh_size_d;
            sh_data_q  <= sh_data_d;
            pdo_st_q   <= pdo_st_d;
            pdo_err_q  <= pdo_err_d;
            pdo_src_q  <= pdo_src_d;
            pdo_size_q <= pdo_size_d;
            pdo_data_q <= pdo_data_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pdo_st   = pdo_st_q;
    assign pdo_err  = pdo_err_q;
    assign pdo_src  = pdo_src_q;
    assign pdo_size = pdo_size_q;
    assign pdo_data = pdo_data_q;
    assign drop_cnt = drop_cnt_q;

endmodule
